sparse_coo_stream_matmul: RTL and testbench



---
 rtl/sparse_coo_stream_matmul.sv | 234 +++++++++++++++++++++++
 tb/tb_sparse_coo_stream_matmul.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_coo_stream_matmul.sv
// Streaming sparse COO matrix multiplier: FP8 (E4M3) A and B entries are
// buffered, every (A, B) pair is visited once, matched products are
// accumulated exactly into a dense C scratchpad, and the non-zero C
// entries are streamed out in row-major order.
module sparse_coo_stream_matmul #(
    parameter int N     = 8,
    parameter int NNZ   = 32,
    parameter int ACC_W = 48,
    parameter int IDX_W = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    a_valid,
    output logic                    a_ready,
    input  logic [IDX_W-1:0]        a_row,
    input  logic [IDX_W-1:0]        a_col,
    input  logic [7:0]              a_data,
    input  logic                    b_valid,
    output logic                    b_ready,
    input  logic [IDX_W-1:0]        b_row,
    input  logic [IDX_W-1:0]        b_col,
    input  logic [7:0]              b_data,
    input  logic                    start,
    output logic                    c_valid,
    input  logic                    c_ready,
    output logic [IDX_W-1:0]        c_row,
    output logic [IDX_W-1:0]        c_col,
    output logic signed [ACC_W-1:0] c_data,
    output logic                    done,
    output logic                    nan_flag
);

    localparam int CNT_W = $clog2(NNZ + 1);
    localparam int PTR_W = (NNZ > 1) ? $clog2(NNZ) : 1;
    localparam int CI_W  = 2 * IDX_W;
    localparam int NC    = N * N;

    typedef enum logic [1:0] {LOAD, COMPUTE, FLUSH, EMIT} state_t;

    state_t state_q, state_d;

    logic [IDX_W-1:0] a_row_mem [NNZ];
    logic [IDX_W-1:0] a_col_mem [NNZ];
    logic [7:0]       a_dat_mem [NNZ];
    logic [IDX_W-1:0] b_row_mem [NNZ];
    logic [IDX_W-1:0] b_col_mem [NNZ];
    logic [7:0]       b_dat_mem [NNZ];

    logic signed [ACC_W-1:0] c_mem [NC];

    logic [CNT_W-1:0] a_count, b_count;
    logic [PTR_W-1:0] ia, ib;
    logic [CI_W-1:0]  scan;
    logic             flush_q;
    logic             done_q, nan_q;

    logic                    vld_p1, match_p1, nan_p1;
    logic signed [ACC_W-1:0] prod_p1;
    logic [CI_W-1:0]         cidx_p1;

    logic a_fire, b_fire, go, issue, last_pair, emit_adv, emit_last, nz;

    // E4M3 NaN is S.1111.111; every other code is a finite value.
    function automatic logic fp8_is_nan(input logic [7:0] v);
        return v[6:0] == 7'h7F;
    endfunction

    // Exact E4M3 x E4M3 product in Q.18: (m'a*m'b) << (ea'+eb'+18), where
    // ea'+eb'+18 == max(ea,1)+max(eb,1)-2, so the shift never goes negative.
    function automatic logic signed [ACC_W-1:0] fp8_product(input logic [7:0] a,
                                                            input logic [7:0] b);
        logic [3:0]       ea, eb, ma, mb;
        logic [4:0]       sh;
        logic [7:0]       mp;
        logic [ACC_W-1:0] mag;
        ea  = (a[6:3] == 4'd0) ? 4'd1 : a[6:3];
        eb  = (b[6:3] == 4'd0) ? 4'd1 : b[6:3];
        ma  = {(a[6:3] != 4'd0), a[2:0]};
        mb  = {(b[6:3] != 4'd0), b[2:0]};
        sh  = {1'b0, ea} + {1'b0, eb} - 5'd2;
        mp  = {4'd0, ma} * {4'd0, mb};
        mag = {{(ACC_W-8){1'b0}}, mp} << sh;
        if (a[7] ^ b[7])
            return -$signed(mag);
        return $signed(mag);
    endfunction

    assign a_fire    = a_valid && a_ready;
    assign b_fire    = b_valid && b_ready;
    assign last_pair = (ia == PTR_W'(a_count - CNT_W'(1))) &&
                       (ib == PTR_W'(b_count - CNT_W'(1)));
    assign nz        = (c_mem[scan] != '0);
    assign done      = done_q;
    assign nan_flag  = nan_q;

    // Phase register.
    always_ff @(posedge clk) begin
        if (!rst_n)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    // Next phase plus the handshake and result-port outputs of each phase.
    always_comb begin
        state_d   = state_q;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        go        = 1'b0;
        issue     = 1'b0;
        emit_adv  = 1'b0;
        emit_last = 1'b0;
        c_valid   = 1'b0;
        c_row     = '0;
        c_col     = '0;
        c_data    = '0;
        case (state_q)
            LOAD: begin
                a_ready = (a_count < CNT_W'(NNZ));
                b_ready = (b_count < CNT_W'(NNZ));
                if (start) begin
                    go      = 1'b1;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (a_count == '0 || b_count == '0) begin
                    state_d = FLUSH;
                end else begin
                    issue = 1'b1;
                    if (last_pair)
                        state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (flush_q)
                    state_d = EMIT;
            end
            EMIT: begin
                c_row    = scan[CI_W-1:IDX_W];
                c_col    = scan[IDX_W-1:0];
                c_data   = c_mem[scan];
                c_valid  = nz;
                emit_adv = !nz || c_ready;
                if (emit_adv && scan == {CI_W{1'b1}}) begin
                    emit_last = 1'b1;
                    state_d   = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // Entry counts, pair/scan indices, flush timer and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
            ia      <= '0;
            ib      <= '0;
            scan    <= '0;
            flush_q <= 1'b0;
            done_q  <= 1'b0;
            nan_q   <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            done_q  <= emit_last;
            vld_p1  <= issue;
            flush_q <= (state_q == FLUSH) ? ~flush_q : 1'b0;
            if (emit_last) begin
                a_count <= '0;
                b_count <= '0;
            end else begin
                if (a_fire)
                    a_count <= a_count + CNT_W'(1);
                if (b_fire)
                    b_count <= b_count + CNT_W'(1);
            end
            if (go) begin
                ia    <= '0;
                ib    <= '0;
                scan  <= '0;
                nan_q <= 1'b0;
            end else begin
                if (issue) begin
                    if (ib == PTR_W'(b_count - CNT_W'(1))) begin
                        ib <= '0;
                        ia <= ia + PTR_W'(1);
                    end else begin
                        ib <= ib + PTR_W'(1);
                    end
                end
                if (emit_adv)
                    scan <= scan + CI_W'(1);
                if (vld_p1 && match_p1 && nan_p1)
                    nan_q <= 1'b1;
            end
        end
    end

    // Entry buffers; a write only happens while the count is below NNZ.
    always_ff @(posedge clk) begin
        if (a_fire) begin
            a_row_mem[a_count[PTR_W-1:0]] <= a_row;
            a_col_mem[a_count[PTR_W-1:0]] <= a_col;
            a_dat_mem[a_count[PTR_W-1:0]] <= a_data;
        end
        if (b_fire) begin
            b_row_mem[b_count[PTR_W-1:0]] <= b_row;
            b_col_mem[b_count[PTR_W-1:0]] <= b_col;
            b_dat_mem[b_count[PTR_W-1:0]] <= b_data;
        end
    end

    // ---- stage 1: coordinate match and exact product of pair (ia, ib) ----
    always_ff @(posedge clk) begin
        match_p1 <= (a_col_mem[ia] == b_row_mem[ib]);
        nan_p1   <= fp8_is_nan(a_dat_mem[ia]) || fp8_is_nan(b_dat_mem[ib]);
        prod_p1  <= (fp8_is_nan(a_dat_mem[ia]) || fp8_is_nan(b_dat_mem[ib])) ?
                    '0 : fp8_product(a_dat_mem[ia], b_dat_mem[ib]);
        cidx_p1  <= {a_row_mem[ia], b_col_mem[ib]};
    end

    // ---- stage 2: single-cycle read-modify-write into the C scratchpad ----
    always_ff @(posedge clk) begin
        if (!rst_n || go) begin
            for (int i = 0; i < NC; i++)
                c_mem[i] <= '0;
        end else if (vld_p1 && match_p1) begin
            c_mem[cidx_p1] <= c_mem[cidx_p1] + prod_p1;
        end
    end

endmodule

// File: tb/tb_sparse_coo_stream_matmul.sv
// Self-checking bench for sparse_coo_stream_matmul: directed scenarios plus
// randomized back-to-back jobs checked against a dense-matrix reference.
module tb_sparse_coo_stream_matmul;

    localparam int N     = 8;
    localparam int NNZ   = 32;
    localparam int ACC_W = 48;
    localparam int IDX_W = 3;

    logic             clk;
    logic             rst_n;
    logic             a_valid, a_ready, b_valid, b_ready;
    logic [IDX_W-1:0] a_row, a_col, b_row, b_col;
    logic [7:0]       a_data, b_data;
    logic             start;
    logic             c_valid, c_ready;
    logic [IDX_W-1:0] c_row, c_col;
    logic signed [ACC_W-1:0] c_data;
    logic             done, nan_flag;

    int total = 0;
    int bad   = 0;

    int la_r[$], la_c[$], la_d[$];
    int lb_r[$], lb_c[$], lb_d[$];
    int ex_r[$], ex_c[$];
    logic [ACC_W-1:0] ex_d[$];
    int ob_r[$], ob_c[$];
    logic [ACC_W-1:0] ob_d[$];
    int done_k, stall_n, unstable_n;

    sparse_coo_stream_matmul #(.N(N), .NNZ(NNZ), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_row(a_row), .a_col(a_col), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_row(b_row), .b_col(b_col), .b_data(b_data),
        .start(start),
        .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row), .c_col(c_col), .c_data(c_data),
        .done(done), .nan_flag(nan_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value of an E4M3 code scaled by 2^9, so every finite code is an integer.
    function automatic longint fp8_scaled(input int d);
        int e, m;
        longint v;
        e = (d >> 3) & 15;
        m = d & 7;
        if (e == 0) v = longint'(m);
        else        v = longint'(8 + m) <<< (e - 1);
        return ((d & 128) != 0) ? -v : v;
    endfunction

    function automatic bit fp8_nan(input int d);
        return (d & 127) == 127;
    endfunction

    function automatic int rand_fp8();
        int d;
        d = $urandom_range(255);
        while (fp8_nan(d)) d = $urandom_range(255);
        return d;
    endfunction

    // Dense reference: C = A*B over the accepted entries, Q.18 = (2^9)*(2^9).
    task automatic build_expected();
        longint cm [N*N];
        ex_r.delete(); ex_c.delete(); ex_d.delete();
        for (int i = 0; i < N*N; i++) cm[i] = 0;
        for (int i = 0; i < la_r.size(); i++)
            for (int j = 0; j < lb_r.size(); j++)
                if (la_c[i] == lb_r[j] && !fp8_nan(la_d[i]) && !fp8_nan(lb_d[j]))
                    cm[la_r[i]*N + lb_c[j]] += fp8_scaled(la_d[i]) * fp8_scaled(lb_d[j]);
        for (int i = 0; i < N*N; i++) begin
            logic [ACC_W-1:0] v;
            v = cm[i][ACC_W-1:0];
            if (v != '0) begin
                ex_r.push_back(i / N);
                ex_c.push_back(i % N);
                ex_d.push_back(v);
            end
        end
    endtask

    task automatic clear_lists();
        la_r.delete(); la_c.delete(); la_d.delete();
        lb_r.delete(); lb_c.delete(); lb_d.delete();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; start = 1'b0; c_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_lists();
    endtask

    task automatic send_entry(input bit isb, input int r, input int c, input int d);
        int k;
        if (!isb) begin
            a_valid = 1'b1; a_row = IDX_W'(r); a_col = IDX_W'(c); a_data = 8'(d);
        end else begin
            b_valid = 1'b1; b_row = IDX_W'(r); b_col = IDX_W'(c); b_data = 8'(d);
        end
        k = 0;
        while (!(isb ? b_ready : a_ready) && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!(isb ? b_ready : a_ready)) begin
            total++; bad++;
            $display("FAIL load_timeout: ready=0 after %0d cycles, required 1", k);
        end else begin
            @(posedge clk); #1;
            if (!isb) begin la_r.push_back(r); la_c.push_back(c); la_d.push_back(d); end
            else      begin lb_r.push_back(r); lb_c.push_back(c); lb_d.push_back(d); end
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    // Offer an A and a B entry in the same cycle.
    task automatic send_both(input int ar, input int ac, input int ad,
                             input int br, input int bc, input int bd);
        int k;
        a_valid = 1'b1; a_row = IDX_W'(ar); a_col = IDX_W'(ac); a_data = 8'(ad);
        b_valid = 1'b1; b_row = IDX_W'(br); b_col = IDX_W'(bc); b_data = 8'(bd);
        k = 0;
        while (!(a_ready && b_ready) && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (!(a_ready && b_ready)) begin
            total++; bad++;
            $display("FAIL load_both_timeout: a_ready=%0b b_ready=%0b, required 1 1", a_ready, b_ready);
        end else begin
            @(posedge clk); #1;
            la_r.push_back(ar); la_c.push_back(ac); la_d.push_back(ad);
            lb_r.push_back(br); lb_c.push_back(bc); lb_d.push_back(bd);
        end
        a_valid = 1'b0; b_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive c_ready (0: always 1, 1: random, 2: stall_len cycles at first valid)
    // and record handshakes until done; done_k counts cycles from the start edge.
    task automatic run_emit(input int mode, input int stall_len);
        int left;
        bit prev_stall;
        int h_r, h_c;
        logic [ACC_W-1:0] h_d;
        ob_r.delete(); ob_c.delete(); ob_d.delete();
        done_k = -1; stall_n = 0; unstable_n = 0; left = stall_len; prev_stall = 0;
        h_r = 0; h_c = 0; h_d = '0;
        for (int k = 1; k <= 4000; k++) begin
            if (mode == 1)      c_ready = ($urandom_range(2) != 0);
            else if (mode == 2) begin
                if (c_valid && left > 0) begin c_ready = 1'b0; left--; end
                else c_ready = 1'b1;
            end else c_ready = 1'b1;
            if (prev_stall && (c_valid !== 1'b1 || int'(c_row) != h_r ||
                               int'(c_col) != h_c || c_data !== h_d))
                unstable_n++;
            if (c_valid && c_ready) begin
                ob_r.push_back(int'(c_row)); ob_c.push_back(int'(c_col)); ob_d.push_back(c_data);
            end
            if (c_valid && !c_ready) stall_n++;
            prev_stall = c_valid && !c_ready;
            h_r = int'(c_row); h_c = int'(c_col); h_d = c_data;
            @(posedge clk); #1;
            if (done) begin done_k = k; break; end
        end
        c_ready = 1'b1;
        if (done_k < 0) begin
            total++; bad++;
            $display("FAIL done_timeout: no done pulse within 4000 cycles");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; start = 1'b0; c_ready = 1'b1;
        a_row = '0; a_col = '0; a_data = '0; b_row = '0; b_col = '0; b_data = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_a_ready: got %b want 1", a_ready); end
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL reset_b_ready: got %b want 1", b_ready); end
        total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL reset_c_valid: got %b want 0", c_valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (nan_flag !== 1'b0) begin bad++; $display("FAIL reset_nan: got %b want 0", nan_flag); end
        total++;
        if (c_row !== '0 || c_col !== '0 || c_data !== '0) begin
            bad++; $display("FAIL reset_c_bus: got (%0d,%0d,%h) want (0,0,0)", c_row, c_col, c_data);
        end
        rst_n = 1'b1;
        clear_lists();
    endtask

    task automatic test_single_product();
        reset_dut();
        send_entry(0, 0, 0, 8'h38);
        send_entry(1, 0, 0, 8'h40);
        do_start();
        run_emit(0, 0);
        total++;
        if (ob_r.size() != 1) begin
            bad++; $display("FAIL single_count: got %0d emits want 1", ob_r.size());
        end else if (ob_r[0] != 0 || ob_c[0] != 0 || ob_d[0] !== 48'h80000) begin
            bad++; $display("FAIL single_emit: got (%0d,%0d,%h) want (0,0,80000)", ob_r[0], ob_c[0], ob_d[0]);
        end
        total++;
        if (done_k != 1 + 2 + N*N) begin
            bad++; $display("FAIL single_done_cycle: got %0d want %0d", done_k, 1 + 2 + N*N);
        end
        @(posedge clk); #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_width: got %b want 0", done); end
    endtask

    task automatic test_accumulate();
        reset_dut();
        send_entry(0, 0, 1, 8'h40);
        send_entry(0, 0, 2, 8'h48);
        send_entry(1, 1, 3, 8'h40);
        send_entry(1, 2, 3, 8'h38);
        // Last B entry handshakes in the same cycle as start.
        b_valid = 1'b1; b_row = 3'd4; b_col = 3'd4; b_data = 8'h38; start = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0; start = 1'b0;
        lb_r.push_back(4); lb_c.push_back(4); lb_d.push_back(8'h38);
        run_emit(0, 0);
        build_expected();
        total++;
        if (ob_r.size() != 1) begin
            bad++; $display("FAIL accum_count: got %0d emits want 1", ob_r.size());
        end else if (ob_r[0] != 0 || ob_c[0] != 3 || ob_d[0] !== 48'h200000) begin
            bad++; $display("FAIL accum_emit: got (%0d,%0d,%h) want (0,3,200000)", ob_r[0], ob_c[0], ob_d[0]);
        end
        total++;
        if (done_k != 6 + 2 + N*N) begin
            bad++; $display("FAIL accum_done_cycle: got %0d want %0d", done_k, 6 + 2 + N*N);
        end
    endtask

    task automatic test_sign_subnormal();
        reset_dut();
        send_both(2, 0, 8'hB8, 0, 5, 8'h01);
        do_start();
        run_emit(0, 0);
        total++;
        if (ob_r.size() != 1) begin
            bad++; $display("FAIL sign_count: got %0d emits want 1", ob_r.size());
        end else if (ob_r[0] != 2 || ob_c[0] != 5 || $signed(ob_d[0]) != -48'sd512) begin
            bad++; $display("FAIL sign_emit: got (%0d,%0d,%h) want (2,5,fffffffffe00)", ob_r[0], ob_c[0], ob_d[0]);
        end
    endtask

    task automatic test_full_backpressure();
        int k;
        reset_dut();
        send_entry(0, 0, 0, 8'h38);
        for (int i = 1; i < NNZ; i++)
            send_entry(0, $urandom_range(N-1), $urandom_range(N-1), rand_fp8());
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL full_a_ready: got %b want 0", a_ready); end
        // 33rd entry would add to C[7][1] if it were wrongly stored.
        a_valid = 1'b1; a_row = 3'd7; a_col = 3'd0; a_data = 8'h38;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (a_ready) k++;
        end
        a_valid = 1'b0;
        total++; if (k != 0) begin bad++; $display("FAIL full_33rd_ready: ready seen %0d cycles want 0", k); end
        send_entry(1, 0, 1, 8'h38);
        do_start();
        run_emit(2, 5);
        build_expected();
        total++;
        if (ob_r.size() != ex_r.size()) begin
            bad++; $display("FAIL full_count: got %0d emits want %0d", ob_r.size(), ex_r.size());
        end else begin
            for (int i = 0; i < ex_r.size(); i++) begin
                total++;
                if (ob_r[i] != ex_r[i] || ob_c[i] != ex_c[i] || ob_d[i] !== ex_d[i]) begin
                    bad++; $display("FAIL full_emit_%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                                    i, ob_r[i], ob_c[i], ob_d[i], ex_r[i], ex_c[i], ex_d[i]);
                end
            end
        end
        total++; if (stall_n != 5) begin bad++; $display("FAIL full_stall_cycles: got %0d want 5", stall_n); end
        total++; if (unstable_n != 0) begin bad++; $display("FAIL full_stable: got %0d changes want 0", unstable_n); end
        total++;
        if (done_k != NNZ + 2 + N*N + 5) begin
            bad++; $display("FAIL full_done_cycle: got %0d want %0d", done_k, NNZ + 2 + N*N + 5);
        end
    endtask

    task automatic test_nan_and_reset();
        reset_dut();
        send_both(0, 0, 8'h7F, 0, 0, 8'h38);
        do_start();
        run_emit(0, 0);
        total++; if (ob_r.size() != 0) begin bad++; $display("FAIL nan_emits: got %0d want 0", ob_r.size()); end
        total++; if (nan_flag !== 1'b1) begin bad++; $display("FAIL nan_flag: got %b want 1", nan_flag); end
        clear_lists();
        for (int i = 0; i < 4; i++) send_both(i, 1, 8'h38, 1, i, 8'h40);
        do_start();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        clear_lists();
        total++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1 || c_valid !== 1'b0 || done !== 1'b0 || nan_flag !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: got ar=%b br=%b cv=%b done=%b nan=%b want 1 1 0 0 0",
                            a_ready, b_ready, c_valid, done, nan_flag);
        end
        send_both(3, 3, 8'h38, 3, 4, 8'h40);
        do_start();
        run_emit(0, 0);
        total++;
        if (ob_r.size() != 1) begin
            bad++; $display("FAIL midreset_discard: got %0d emits want 1", ob_r.size());
        end else if (ob_r[0] != 3 || ob_c[0] != 4 || ob_d[0] !== 48'h80000) begin
            bad++; $display("FAIL midreset_emit: got (%0d,%0d,%h) want (3,4,80000)", ob_r[0], ob_c[0], ob_d[0]);
        end
        total++;
        if (done_k != 1 + 2 + N*N) begin
            bad++; $display("FAIL midreset_done_cycle: got %0d want %0d", done_k, 1 + 2 + N*N);
        end
    endtask

    // Randomized jobs run back to back with no reset in between.
    task automatic test_back_to_back();
        reset_dut();
        for (int it = 0; it < 6; it++) begin
            int na, nb, m;
            clear_lists();
            na = 1 + $urandom_range(7);
            nb = 1 + $urandom_range(7);
            m  = (na < nb) ? na : nb;
            for (int i = 0; i < m; i++)
                send_both($urandom_range(N-1), $urandom_range(3), rand_fp8(),
                          $urandom_range(3), $urandom_range(N-1), rand_fp8());
            for (int i = m; i < na; i++)
                send_entry(0, $urandom_range(N-1), $urandom_range(3), rand_fp8());
            for (int i = m; i < nb; i++)
                send_entry(1, $urandom_range(3), $urandom_range(N-1), rand_fp8());
            do_start();
            run_emit(1, 0);
            build_expected();
            total++;
            if (ob_r.size() != ex_r.size()) begin
                bad++; $display("FAIL rand%0d_count: got %0d emits want %0d", it, ob_r.size(), ex_r.size());
            end else begin
                for (int i = 0; i < ex_r.size(); i++) begin
                    total++;
                    if (ob_r[i] != ex_r[i] || ob_c[i] != ex_c[i] || ob_d[i] !== ex_d[i]) begin
                        bad++; $display("FAIL rand%0d_emit_%0d: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                                        it, i, ob_r[i], ob_c[i], ob_d[i], ex_r[i], ex_c[i], ex_d[i]);
                    end
                end
            end
            total++;
            if (done_k != la_r.size() * lb_r.size() + 2 + N*N + stall_n) begin
                bad++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", it, done_k,
                                la_r.size() * lb_r.size() + 2 + N*N + stall_n);
            end
            total++; if (nan_flag !== 1'b0) begin bad++; $display("FAIL rand%0d_nan: got %b want 0", it, nan_flag); end
        end
    endtask

    initial begin
        test_reset();
        test_single_product();
        test_accumulate();
        test_sign_subnormal();
        test_full_backpressure();
        test_nan_and_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
